// File: rtl/seg_frame_rx_pkg.sv
// Shared definitions for the serial seven-segment frame receiver.
// Holds the frame FSM encoding, the active-low segment pattern table,
// frame/digit sizing and a helper that decodes the digit-select byte.
package seg_frame_rx_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE,   // no bits received
        ST_SHIFT,  // 1..15 bits received
        ST_FULL,   // exactly 16 bits received
        ST_OVER    // more than 16 bits received
    } frame_state_t;

    // Active-low segment patterns for hex digits 0..F, indexed by nibble.
    localparam logic [7:0] SEG_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef struct packed {
        logic       vld;
        logic [1:0] idx;
    } sel_dec_t;

    // Active-low select: upper nibble all ones, exactly one zero in the
    // lower nibble; the position of that zero is the digit index.
    function automatic sel_dec_t sel_decode(input logic [7:0] sel);
        sel_dec_t r;
        r.vld = 1'b0;
        r.idx = 2'd0;
        if (sel[7:4] == 4'hF) begin
            case (sel[3:0])
                4'hE: begin r.vld = 1'b1; r.idx = 2'd0; end
                4'hD: begin r.vld = 1'b1; r.idx = 2'd1; end
                4'hB: begin r.vld = 1'b1; r.idx = 2'd2; end
                4'h7: begin r.vld = 1'b1; r.idx = 2'd3; end
                default: begin r.vld = 1'b0; r.idx = 2'd0; end
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_frame_rx_decode.sv
// Combinational segment-pattern decoder.
// Ports:
//   i_seg  - active-low segment byte (bit 7 = decimal point, ignored)
//   o_nib  - decoded hex nibble (0 when not decodable)
//   o_vld  - high when the pattern matches a table entry
module seg_decode
    import seg_frame_rx_pkg::*;
(
    input  logic [7:0] i_seg,
    output logic [3:0] o_nib,
    output logic       o_vld
);

    always_comb begin
        o_nib = '0;
        o_vld = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i_seg[6:0] == SEG_TABLE[i][6:0]) begin
                o_nib = 4'(i);
                o_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_frame_rx.sv
// Receiver for a shift-register style seven-segment display link.
// Serial data is shifted in on ds_shcp rising edges and framed by
// ds_stcp; each 16-bit frame carries {select, segment} bytes (active-low)
// for one digit. When all four digits have been written, the assembled
// hex value is presented on dout with a dout_vld pulse.
// Ports:
//   clk, rst  - system clock, asynchronous active-high reset
//   ds_data   - serial data (async)
//   ds_shcp   - shift clock (async), data valid on rising edge
//   ds_stcp   - latch strobe (async), rising edge ends a frame
//   dout      - recovered value, digit3 in [15:12] .. digit0 in [3:0]
//   dout_vld  - one-cycle pulse when dout updates
//   frm_err   - one-cycle pulse: latch with bit count != 16
//   code_err  - one-cycle pulse: undecodable segment or select byte
//   link_up   - high while latch strobes keep arriving within TIMEOUT_CNT
module seg_frame_rx
    import seg_frame_rx_pkg::*;
#(
    parameter int unsigned TIMEOUT_CNT = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ds_data,
    input  logic        ds_shcp,
    input  logic        ds_stcp,
    output logic [15:0] dout,
    output logic        dout_vld,
    output logic        frm_err,
    output logic        code_err,
    output logic        link_up
);

    localparam int unsigned TO_W = (TIMEOUT_CNT > 1) ? $clog2(TIMEOUT_CNT) : 1;

    // Synchronizers and edge detect
    logic r_data_s1, r_data_s2;
    logic r_shcp_s1, r_shcp_s2, r_shcp_s3;
    logic r_stcp_s1, r_stcp_s2, r_stcp_s3;
    logic w_sh_rise, w_st_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_s1 <= 1'b0;
            r_data_s2 <= 1'b0;
            r_shcp_s1 <= 1'b0;
            r_shcp_s2 <= 1'b0;
            r_shcp_s3 <= 1'b0;
            r_stcp_s1 <= 1'b0;
            r_stcp_s2 <= 1'b0;
            r_stcp_s3 <= 1'b0;
        end else begin
            r_data_s1 <= ds_data;
            r_data_s2 <= r_data_s1;
            r_shcp_s1 <= ds_shcp;
            r_shcp_s2 <= r_shcp_s1;
            r_shcp_s3 <= r_shcp_s2;
            r_stcp_s1 <= ds_stcp;
            r_stcp_s2 <= r_stcp_s1;
            r_stcp_s3 <= r_stcp_s2;
        end
    end

    assign w_sh_rise = r_shcp_s2 & ~r_shcp_s3;
    assign w_st_rise = r_stcp_s2 & ~r_stcp_s3;

    // Frame FSM and shift register
    frame_state_t r_state, w_state_nxt;
    logic [4:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic [15:0]  r_shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
        end
    end

    // A latch strobe wins over a coincident shift edge; that shift is dropped.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        if (w_st_rise) begin
            w_state_nxt   = ST_IDLE;
            w_bit_cnt_nxt = '0;
        end else if (w_sh_rise) begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt   = ST_SHIFT;
                    w_bit_cnt_nxt = 5'd1;
                end
                ST_SHIFT: begin
                    w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                    if (r_bit_cnt == 5'(FRAME_BITS - 1)) begin
                        w_state_nxt = ST_FULL;
                    end
                end
                ST_FULL: begin
                    w_state_nxt   = ST_OVER;
                    w_bit_cnt_nxt = 5'(FRAME_BITS + 1);
                end
                ST_OVER: begin
                    w_state_nxt   = ST_OVER;
                end
                default: begin
                    w_state_nxt   = ST_IDLE;
                    w_bit_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg <= '0;
        end else if (w_sh_rise && !w_st_rise) begin
            r_shreg <= {r_shreg[14:0], r_data_s2};
        end
    end

    // Latch stage: capture the frame on the strobe edge
    logic       r_lat_frame;
    logic       r_lat_bad;
    logic [7:0] r_lat_sel;
    logic [7:0] r_lat_seg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lat_frame <= 1'b0;
            r_lat_bad   <= 1'b0;
            r_lat_sel   <= '0;
            r_lat_seg   <= '0;
        end else begin
            r_lat_frame <= w_st_rise && (r_state == ST_FULL);
            r_lat_bad   <= w_st_rise && (r_state != ST_FULL);
            if (w_st_rise && (r_state == ST_FULL)) begin
                r_lat_sel <= r_shreg[15:8];
                r_lat_seg <= r_shreg[7:0];
            end
        end
    end

    // Decode/store stage
    logic [3:0]                  w_nib;
    logic                        w_seg_vld;
    sel_dec_t                    w_sel;
    logic                        w_frame_ok;
    logic [NUM_DIGITS-1:0][3:0]  r_digit, w_digit_nxt;
    logic [NUM_DIGITS-1:0]       r_written, w_written_nxt;

    seg_decode u_seg_decode (
        .i_seg (r_lat_seg),
        .o_nib (w_nib),
        .o_vld (w_seg_vld)
    );

    assign w_sel      = sel_decode(r_lat_sel);
    assign w_frame_ok = r_lat_frame & w_sel.vld & w_seg_vld;

    always_comb begin
        w_digit_nxt   = r_digit;
        w_written_nxt = r_written;
        if (w_frame_ok) begin
            w_digit_nxt[w_sel.idx]   = w_nib;
            w_written_nxt[w_sel.idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digit   <= '0;
            r_written <= '0;
            dout      <= '0;
            dout_vld  <= 1'b0;
            frm_err   <= 1'b0;
            code_err  <= 1'b0;
        end else begin
            dout_vld <= 1'b0;
            frm_err  <= r_lat_bad;
            code_err <= r_lat_frame & ~(w_sel.vld & w_seg_vld);
            r_digit  <= w_digit_nxt;
            // Publishing uses the next-digit view so the completing write
            // is included in the same cycle it lands.
            if (w_written_nxt == '1) begin
                dout      <= w_digit_nxt;
                dout_vld  <= 1'b1;
                r_written <= '0;
            end else begin
                r_written <= w_written_nxt;
            end
        end
    end

    // Link supervision
    logic [TO_W-1:0] r_to_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
            link_up  <= 1'b0;
        end else if (w_st_rise) begin
            r_to_cnt <= '0;
            link_up  <= 1'b1;
        end else if (r_to_cnt == TO_W'(TIMEOUT_CNT - 1)) begin
            link_up  <= 1'b0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

endmodule

// File: tb/tb_seg_frame_rx.sv
module tb_seg_frame_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        ds_data;
    logic        ds_shcp;
    logic        ds_stcp;
    logic [15:0] dout;
    logic        dout_vld;
    logic        frm_err;
    logic        code_err;
    logic        link_up;

    int errors = 0;
    int checks = 0;
    int n_vld  = 0;
    int n_ferr = 0;
    int n_cerr = 0;

    seg_frame_rx #(.TIMEOUT_CNT(100)) dut (
        .clk      (clk),
        .rst      (rst),
        .ds_data  (ds_data),
        .ds_shcp  (ds_shcp),
        .ds_stcp  (ds_stcp),
        .dout     (dout),
        .dout_vld (dout_vld),
        .frm_err  (frm_err),
        .code_err (code_err),
        .link_up  (link_up)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dout_vld) n_vld++;
        if (frm_err)  n_ferr++;
        if (code_err) n_cerr++;
    end

    task automatic shift_bit(input logic b);
        @(negedge clk);
        ds_data = b;
        repeat (3) @(negedge clk);
        ds_shcp = 1'b1;
        repeat (3) @(negedge clk);
        ds_shcp = 1'b0;
    endtask

    task automatic latch();
        @(negedge clk);
        ds_stcp = 1'b1;
        repeat (3) @(negedge clk);
        ds_stcp = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] sel, input logic [7:0] seg);
        logic [15:0] w;
        w = {sel, seg};
        for (int i = 15; i >= 0; i--) shift_bit(w[i]);
        latch();
    endtask

    task automatic test_reset();
        rst = 1'b1; ds_data = 1'b0; ds_shcp = 1'b0; ds_stcp = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL reset_dout: got %h expected 0000", dout); end
        checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL reset_dout_vld: got %b expected 0", dout_vld); end
        checks++; if (frm_err !== 1'b0) begin errors++; $display("FAIL reset_frm_err: got %b expected 0", frm_err); end
        checks++; if (code_err !== 1'b0) begin errors++; $display("FAIL reset_code_err: got %b expected 0", code_err); end
        checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL reset_link_up: got %b expected 0", link_up); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Strobe with no bits: frm_err exactly on the 4th clock edge after the
    // first edge that samples ds_stcp high, one cycle wide.
    task automatic test_latency();
        @(negedge clk);
        ds_stcp = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (frm_err !== 1'b0) begin errors++; $display("FAIL latency_early: frm_err got %b expected 0", frm_err); end
        @(posedge clk); #1;
        checks++; if (frm_err !== 1'b1) begin errors++; $display("FAIL latency_on_time: frm_err got %b expected 1", frm_err); end
        @(posedge clk); #1;
        checks++; if (frm_err !== 1'b0) begin errors++; $display("FAIL latency_one_cycle: frm_err got %b expected 0", frm_err); end
        checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL latency_link_up: got %b expected 1", link_up); end
        @(negedge clk);
        ds_stcp = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_full_frames();
        int v0, f0, c0;
        v0 = n_vld; f0 = n_ferr; c0 = n_cerr;
        send_frame(8'hFE, 8'h86);
        send_frame(8'hFD, 8'hA1);
        send_frame(8'hFB, 8'hC6);
        checks++; if (n_vld - v0 !== 0) begin errors++; $display("FAIL full_partial_vld: got %0d pulses expected 0", n_vld - v0); end
        send_frame(8'hF7, 8'h83);
        checks++; if (n_vld - v0 !== 1) begin errors++; $display("FAIL full_vld: got %0d pulses expected 1", n_vld - v0); end
        checks++; if (dout !== 16'hBCDE) begin errors++; $display("FAIL full_dout: got %h expected BCDE", dout); end
        checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL full_frm_err: got %0d expected 0", n_ferr - f0); end
        checks++; if (n_cerr - c0 !== 0) begin errors++; $display("FAIL full_code_err: got %0d expected 0", n_cerr - c0); end
    endtask

    task automatic test_code_err();
        int v0, f0, c0;
        v0 = n_vld; f0 = n_ferr; c0 = n_cerr;
        send_frame(8'hFE, 8'hFF);
        checks++; if (n_cerr - c0 !== 1) begin errors++; $display("FAIL code_bad_seg: got %0d expected 1", n_cerr - c0); end
        send_frame(8'hFC, 8'hC0);
        checks++; if (n_cerr - c0 !== 2) begin errors++; $display("FAIL code_bad_sel: got %0d expected 2", n_cerr - c0); end
        checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL code_frm_err: got %0d expected 0", n_ferr - f0); end
        // Digit 0 must still be unwritten: three more digits give no output.
        send_frame(8'hFD, 8'h99);
        send_frame(8'hFB, 8'h92);
        send_frame(8'hF7, 8'h82);
        checks++; if (n_vld - v0 !== 0) begin errors++; $display("FAIL code_written_clear: got %0d pulses expected 0", n_vld - v0); end
        send_frame(8'hFE, 8'hC0);
        checks++; if (n_vld - v0 !== 1) begin errors++; $display("FAIL code_recover_vld: got %0d pulses expected 1", n_vld - v0); end
        checks++; if (dout !== 16'h6540) begin errors++; $display("FAIL code_recover_dout: got %h expected 6540", dout); end
    endtask

    task automatic test_short_frame();
        int v0, f0, c0;
        v0 = n_vld; f0 = n_ferr; c0 = n_cerr;
        for (int i = 0; i < 15; i++) shift_bit(1'(i));
        latch();
        checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL short_frm_err: got %0d expected 1", n_ferr - f0); end
        checks++; if (dout !== 16'h6540) begin errors++; $display("FAIL short_dout: got %h expected 6540", dout); end
        // Following frame must start from an empty bit count.
        send_frame(8'hFE, 8'h99);
        checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL short_then_full_frm: got %0d expected 1", n_ferr - f0); end
        checks++; if (n_cerr - c0 !== 0) begin errors++; $display("FAIL short_then_full_code: got %0d expected 0", n_cerr - c0); end
        checks++; if (n_vld - v0 !== 0) begin errors++; $display("FAIL short_vld: got %0d expected 0", n_vld - v0); end
    endtask

    task automatic test_long_frame();
        int v0, f0, c0;
        v0 = n_vld; f0 = n_ferr; c0 = n_cerr;
        for (int i = 0; i < 17; i++) shift_bit(1'b1);
        latch();
        checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL long_frm_err: got %0d expected 1", n_ferr - f0); end
        checks++; if (n_vld - v0 !== 0) begin errors++; $display("FAIL long_vld: got %0d expected 0", n_vld - v0); end
        checks++; if (n_cerr - c0 !== 0) begin errors++; $display("FAIL long_code_err: got %0d expected 0", n_cerr - c0); end
    endtask

    // Digit 0 already holds 4; overwrite with 8 (seg 00: dp bit ignored).
    task automatic test_rewrite();
        int v0;
        v0 = n_vld;
        send_frame(8'hFE, 8'h00);
        send_frame(8'hFD, 8'hF9);
        send_frame(8'hFB, 8'hA4);
        checks++; if (n_vld - v0 !== 0) begin errors++; $display("FAIL rewrite_early_vld: got %0d expected 0", n_vld - v0); end
        send_frame(8'hF7, 8'hB0);
        checks++; if (n_vld - v0 !== 1) begin errors++; $display("FAIL rewrite_vld: got %0d expected 1", n_vld - v0); end
        checks++; if (dout !== 16'h3218) begin errors++; $display("FAIL rewrite_dout: got %h expected 3218", dout); end
    endtask

    task automatic test_reset_mid_frame();
        int v0, f0, c0;
        logic [7:0] b;
        b = 8'hFE;
        for (int i = 7; i >= 0; i--) shift_bit(b[i]);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL midrst_dout: got %h expected 0000", dout); end
        checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL midrst_link_up: got %b expected 0", link_up); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        v0 = n_vld; f0 = n_ferr; c0 = n_cerr;
        // Only 8 bits since reset: must be a framing error.
        b = 8'hC0;
        for (int i = 7; i >= 0; i--) shift_bit(b[i]);
        latch();
        checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL midrst_first_latch: got %0d expected 1", n_ferr - f0); end
        send_frame(8'hFE, 8'hC0);
        checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL midrst_full_frm: got %0d expected 1", n_ferr - f0); end
        checks++; if (n_cerr - c0 !== 0) begin errors++; $display("FAIL midrst_full_code: got %0d expected 0", n_cerr - c0); end
        send_frame(8'hFD, 8'hF9);
        send_frame(8'hFB, 8'hA4);
        send_frame(8'hF7, 8'hB0);
        checks++; if (n_vld - v0 !== 1) begin errors++; $display("FAIL midrst_vld: got %0d expected 1", n_vld - v0); end
        checks++; if (dout !== 16'h3210) begin errors++; $display("FAIL midrst_dout: got %h expected 3210", dout); end
    endtask

    // Strobe detected on edge 3; counter runs 0..99 and link_up drops on
    // edge 103, so it first reads low at negedge 103.
    task automatic test_timeout();
        int fall_at;
        int rise_at;
        fall_at = -1;
        rise_at = -1;
        @(negedge clk);
        ds_stcp = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 3) ds_stcp = 1'b0;
            if (k == 50) begin
                checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL timeout_mid: link_up got %b expected 1", link_up); end
            end
            if (k > 5 && link_up === 1'b0) begin
                fall_at = k;
                break;
            end
        end
        checks++; if (fall_at !== 103) begin errors++; $display("FAIL timeout_fall: fell at cycle %0d expected 103", fall_at); end
        repeat (5) @(negedge clk);
        checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL timeout_hold: link_up got %b expected 0", link_up); end
        ds_stcp = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 3) ds_stcp = 1'b0;
            if (link_up === 1'b1) begin
                rise_at = k;
                break;
            end
        end
        checks++; if (rise_at !== 3) begin errors++; $display("FAIL timeout_rise: rose at cycle %0d expected 3", rise_at); end
        ds_stcp = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_full_frames();
        test_code_err();
        test_short_frame();
        test_long_frame();
        test_rewrite();
        test_reset_mid_frame();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
